// File: rtl/eth_rx_frame_filter_pkg.sv
// Shared beat layout and write-FSM encodings for the RX frame filter.
package eth_rx_frame_filter_pkg;
  localparam int DATA_W = 64;
  localparam int USER_W = 80;
  localparam int KEEP_W = 8;
  localparam int BEAT_W = DATA_W + USER_W + KEEP_W + 1;

  typedef struct packed {
    logic              last;
    logic [KEEP_W-1:0] keep;
    logic [USER_W-1:0] user;
    logic [DATA_W-1:0] data;
  } beat_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RECV     = 2'd1,
    ST_WAIT_CRC = 2'd2,
    ST_DISCARD  = 2'd3
  } wr_state_e;
endpackage

// File: rtl/rx_sdp_ram.sv
// Simple dual-port frame buffer: port a writes, port b reads with one cycle latency.
module rx_sdp_ram #(
  parameter int P_ADDR_W = 9,
  parameter int P_DATA_W = 153
) (
  input  logic                i_clk,
  input  logic                i_a_we,
  input  logic [P_ADDR_W-1:0] i_a_addr,
  input  logic [P_DATA_W-1:0] i_a_din,
  input  logic                i_b_re,
  input  logic [P_ADDR_W-1:0] i_b_addr,
  output logic [P_DATA_W-1:0] o_b_dout
);
  logic [P_DATA_W-1:0] r_mem [2**P_ADDR_W];

  always_ff @(posedge i_clk) begin
    if (i_a_we) r_mem[i_a_addr] <= i_a_din;
    if (i_b_re) o_b_dout <= r_mem[i_b_addr];
  end
endmodule

// File: rtl/eth_rx_frame_filter.sv
// Store-and-forward RX filter: frames are buffered until the CRC verdict and released only when good.
// state       | meaning
// ST_IDLE     | no frame in progress, wr_ptr == commit_ptr
// ST_RECV     | writing beats of the current frame
// ST_WAIT_CRC | whole frame buffered, waiting for the verdict (bounded by timer)
// ST_DISCARD  | frame refused (full or oversize), swallowing beats until rlast
module eth_rx_frame_filter
  import eth_rx_frame_filter_pkg::*;
#(
  parameter int P_ADDR_W      = 9,
  parameter int P_MAX_BEATS   = 190,
  parameter int P_CRC_TIMEOUT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] s_axis_rdata,
  input  logic [USER_W-1:0] s_axis_ruser,
  input  logic [KEEP_W-1:0] s_axis_rkeep,
  input  logic              s_axis_rlast,
  input  logic              s_axis_rvalid,
  input  logic              i_crc_valid,
  input  logic              i_crc_error,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [USER_W-1:0] m_axis_tuser,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [15:0]       o_frame_ok_cnt,
  output logic [15:0]       o_frame_drop_cnt,
  output logic              o_overflow
);
  localparam int PTR_W = P_ADDR_W + 1;
  localparam int CNT_W = $clog2(P_MAX_BEATS + 1) + 1;
  localparam int TMR_W = $clog2(P_CRC_TIMEOUT + 1) + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] FULL_LVL = {1'b1, {P_ADDR_W{1'b0}}};

  wr_state_e r_state, w_state_nxt;
  logic [PTR_W-1:0] r_wr, r_cm, r_rd, w_wr_nxt, w_cm_nxt, w_base;
  logic [CNT_W-1:0] r_beats, w_beats_nxt;
  logic [TMR_W-1:0] r_tmr, w_tmr_nxt;
  logic r_disc_full, w_disc_full_nxt;
  logic w_in_wait, w_pend_ok, w_pend_bad, w_full, w_start, w_cont;
  logic w_refuse, w_write, w_end_vrd, w_ok_inc, w_ovf_set;
  logic [1:0] w_drop_inc;
  beat_t w_wbeat;

  // A beat in WAIT_CRC without a verdict abandons the pending frame, so it writes at commit_ptr.
  assign w_in_wait  = (r_state == ST_WAIT_CRC);
  assign w_pend_ok  = w_in_wait && i_crc_valid && !i_crc_error;
  assign w_pend_bad = w_in_wait && !w_pend_ok && (i_crc_valid || s_axis_rvalid || r_tmr == '0);
  assign w_base     = w_pend_bad ? r_cm : r_wr;
  assign w_full     = ((w_base - r_rd) == FULL_LVL);
  assign w_start    = s_axis_rvalid && (r_state == ST_IDLE || w_in_wait);
  assign w_cont     = s_axis_rvalid && (r_state == ST_RECV);
  assign w_refuse   = (w_start || w_cont) && (w_full || (w_cont && r_beats == CNT_W'(P_MAX_BEATS)));
  assign w_write    = (w_start || w_cont) && !w_refuse;
  assign w_end_vrd  = w_write && s_axis_rlast && i_crc_valid && !w_in_wait;
  assign w_wbeat    = {s_axis_rlast, s_axis_rkeep, s_axis_ruser, s_axis_rdata};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_start || w_cont) begin
      if (w_refuse)          w_state_nxt = s_axis_rlast ? ST_IDLE : ST_DISCARD;
      else if (s_axis_rlast) w_state_nxt = w_end_vrd ? ST_IDLE : ST_WAIT_CRC;
      else                   w_state_nxt = ST_RECV;
    end else if (r_state == ST_DISCARD) begin
      if (s_axis_rvalid && s_axis_rlast) w_state_nxt = ST_IDLE;
    end else if (w_pend_ok || w_pend_bad) begin
      w_state_nxt = ST_IDLE;
    end
  end

  always_comb begin
    w_wr_nxt        = r_wr;
    w_cm_nxt        = r_cm;
    w_beats_nxt     = r_beats;
    w_tmr_nxt       = r_tmr;
    w_disc_full_nxt = r_disc_full;
    w_ok_inc        = 1'b0;
    w_drop_inc      = 2'd0;
    w_ovf_set       = 1'b0;
    if (w_pend_ok) begin
      w_cm_nxt = r_wr;
      w_ok_inc = 1'b1;
    end
    if (w_pend_bad) begin
      w_wr_nxt   = r_cm;
      w_drop_inc = 2'd1;
    end
    if (w_in_wait && r_tmr != '0) w_tmr_nxt = r_tmr - TMR_W'(1);
    if (w_write) begin
      w_wr_nxt    = w_base + PTR_ONE;
      w_beats_nxt = w_start ? CNT_W'(1) : r_beats + CNT_W'(1);
      if (s_axis_rlast) begin
        w_tmr_nxt = TMR_W'(P_CRC_TIMEOUT - 1);
        if (w_end_vrd && !i_crc_error) begin
          w_cm_nxt = w_base + PTR_ONE;
          w_ok_inc = 1'b1;
        end else if (w_end_vrd) begin
          w_wr_nxt   = r_cm;
          w_drop_inc = w_drop_inc + 2'd1;
        end
      end
    end else if (w_refuse) begin
      if (s_axis_rlast) begin
        w_wr_nxt   = w_cm_nxt;
        w_drop_inc = w_drop_inc + 2'd1;
        w_ovf_set  = w_full;
      end else begin
        w_disc_full_nxt = w_full;
      end
    end else if (r_state == ST_DISCARD && s_axis_rvalid && s_axis_rlast) begin
      w_wr_nxt   = r_cm;
      w_drop_inc = 2'd1;
      w_ovf_set  = r_disc_full;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr             <= '0;
      r_cm             <= '0;
      r_beats          <= '0;
      r_tmr            <= '0;
      r_disc_full      <= 1'b0;
      o_frame_ok_cnt   <= '0;
      o_frame_drop_cnt <= '0;
      o_overflow       <= 1'b0;
    end else begin
      r_wr             <= w_wr_nxt;
      r_cm             <= w_cm_nxt;
      r_beats          <= w_beats_nxt;
      r_tmr            <= w_tmr_nxt;
      r_disc_full      <= w_disc_full_nxt;
      o_frame_ok_cnt   <= o_frame_ok_cnt + 16'(w_ok_inc);
      o_frame_drop_cnt <= o_frame_drop_cnt + 16'(w_drop_inc);
      if (w_ovf_set) o_overflow <= 1'b1;
    end
  end

  // Read side: RAM read in flight plus two skid entries never exceed two beats.
  logic [BEAT_W-1:0] w_ram_q;
  beat_t r_buf [2];
  beat_t w_head;
  logic [1:0] r_occ, w_used;
  logic r_hd, r_rd_pend, w_pop, w_rd_issue, w_tail;

  assign w_pop      = m_axis_tvalid && m_axis_tready;
  assign w_used     = r_occ + {1'b0, r_rd_pend} - {1'b0, w_pop};
  assign w_rd_issue = (r_rd != r_cm) && (w_used < 2'd2);
  assign w_tail     = r_hd ^ (r_occ == 2'd1);
  assign w_head     = r_buf[r_hd];

  rx_sdp_ram #(.P_ADDR_W(P_ADDR_W), .P_DATA_W(BEAT_W)) u_ram (
    .i_clk    (i_clk),
    .i_a_we   (w_write),
    .i_a_addr (w_base[P_ADDR_W-1:0]),
    .i_a_din  (w_wbeat),
    .i_b_re   (w_rd_issue),
    .i_b_addr (r_rd[P_ADDR_W-1:0]),
    .o_b_dout (w_ram_q)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd      <= '0;
      r_rd_pend <= 1'b0;
      r_occ     <= '0;
      r_hd      <= 1'b0;
      for (int i = 0; i < 2; i++) r_buf[i] <= '0;
    end else begin
      if (w_rd_issue) r_rd <= r_rd + PTR_ONE;
      r_rd_pend <= w_rd_issue;
      if (r_rd_pend) r_buf[w_tail] <= beat_t'(w_ram_q);
      if (w_pop) r_hd <= ~r_hd;
      r_occ <= r_occ + {1'b0, r_rd_pend} - {1'b0, w_pop};
    end
  end

  assign m_axis_tvalid = (r_occ != 2'd0);
  assign m_axis_tdata  = w_head.data;
  assign m_axis_tuser  = w_head.user;
  assign m_axis_tkeep  = w_head.keep;
  assign m_axis_tlast  = w_head.last;
endmodule

// File: tb/tb_eth_rx_frame_filter.sv
// Scoreboard bench: frame-level model decides commit/drop, monitor checks every released beat.
module tb_eth_rx_frame_filter;
  import eth_rx_frame_filter_pkg::*;

  localparam int DEPTH = 512;
  localparam int MAXB  = 190;
  localparam int TO    = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [63:0] rdata = '0;
  logic [79:0] ruser = '0;
  logic [7:0]  rkeep = '0;
  logic rlast = 1'b0, rvalid = 1'b0, crc_valid = 1'b0, crc_error = 1'b0;
  logic [63:0] tdata;
  logic [79:0] tuser;
  logic [7:0]  tkeep;
  logic tlast, tvalid;
  logic tready = 1'b1;
  logic [15:0] ok_cnt, drop_cnt;
  logic ovf;

  int n_chk = 0, n_pass = 0;
  int exp_ok = 0, exp_drop = 0;
  int rdy_mode = 1;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  eth_rx_frame_filter #(.P_ADDR_W(9), .P_MAX_BEATS(MAXB), .P_CRC_TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .s_axis_rdata(rdata), .s_axis_ruser(ruser), .s_axis_rkeep(rkeep),
    .s_axis_rlast(rlast), .s_axis_rvalid(rvalid),
    .i_crc_valid(crc_valid), .i_crc_error(crc_error),
    .m_axis_tdata(tdata), .m_axis_tuser(tuser), .m_axis_tkeep(tkeep),
    .m_axis_tlast(tlast), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .o_frame_ok_cnt(ok_cnt), .o_frame_drop_cnt(drop_cnt), .o_overflow(ovf)
  );

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       tready = 1'b0;
      1:       tready = 1'b1;
      default: tready = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: pops the expected beat on every handshake, and holds a stalled beat to its last value.
  beat_t prev, cur;
  bit prev_stall = 1'b0;
  always @(negedge clk) begin
    cur = {tlast, tkeep, tuser, tdata};
    if (!rst_n) prev_stall = 1'b0;
    else begin
      if (prev_stall) check("stall_hold", 160'({tvalid, cur}), 160'({1'b1, prev}));
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_beat: got %h expected no beat", cur);
        end else begin
          check("beat", 160'(cur), 160'(exp_q.pop_front()));
        end
      end
      prev_stall = tvalid && !tready;
      prev = cur;
    end
  end

  // Frame-level rule: commits only with a good verdict inside the window and a legal length.
  function automatic bit good_expected(input int len, input int vdelay, input bit err);
    return !err && vdelay >= 0 && vdelay <= TO && len <= MAXB;
  endfunction

  // vdelay: 0 = verdict with rlast, k = k cycles later, -1 = none; tail=0 returns right after rlast.
  task automatic send_frame(input int len, input int vdelay, input bit err, input bit exp_good, input bit tail);
    beat_t b;
    logic [95:0] u;
    for (int i = 0; i < len; i++) begin
      u = {$urandom, $urandom, $urandom};
      b.data = {$urandom, $urandom};
      b.user = u[79:0];
      b.keep = 8'($urandom);
      b.last = (i == len - 1);
      if (exp_good) exp_q.push_back(b);
      @(posedge clk); #1;
      rvalid = 1'b1; rdata = b.data; ruser = b.user; rkeep = b.keep; rlast = b.last;
      crc_valid = b.last && (vdelay == 0);
      crc_error = err;
    end
    if (exp_good) exp_ok++;
    else exp_drop++;
    if (tail) begin
      for (int k = 1; k <= 6; k++) begin
        @(posedge clk); #1;
        rvalid = 1'b0; rlast = 1'b0;
        crc_valid = (k == vdelay);
        crc_error = err;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rvalid = 1'b0; rlast = 1'b0; crc_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input int budget);
    int b;
    b = budget;
    while (exp_q.size() != 0 && b > 0) begin
      @(posedge clk);
      b--;
    end
    check("drain_empty", 160'(exp_q.size()), 160'(0));
    idle(4);
  endtask

  task automatic wait_room(input int len);
    int b;
    b = 5000;
    while (exp_q.size() + len > DEPTH && b > 0) begin
      @(posedge clk);
      b--;
    end
    if (exp_q.size() + len > DEPTH) begin
      n_chk++;
      $display("FAIL room_wait: outstanding %0d beats, need room for %0d", exp_q.size(), len);
    end
  endtask

  task automatic check_cnts(input string tag);
    check({tag, "_ok_cnt"}, 160'(ok_cnt), 160'(16'(exp_ok)));
    check({tag, "_drop_cnt"}, 160'(drop_cnt), 160'(16'(exp_drop)));
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, vd, ok0, drop0;
    bit err;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 160'(tvalid), 160'(0));
    check("rst_outputs", 160'({tlast, tkeep, tdata, tuser, ok_cnt, drop_cnt, ovf}), 160'(0));
    rst_n = 1'b1;
    idle(2);

    // Good 8-beat frame, verdict two cycles after rlast.
    send_frame(8, 2, 1'b0, good_expected(8, 2, 1'b0), 1'b1);
    wait_drain(200);
    check_cnts("t1");

    // Bad CRC is dropped, the following good frame passes intact.
    send_frame(8, 2, 1'b1, good_expected(8, 2, 1'b1), 1'b1);
    send_frame(4, 1, 1'b0, good_expected(4, 1, 1'b0), 1'b1);
    wait_drain(200);
    check_cnts("t2");

    // Missing verdict times out (late strobe ignored); verdict at the window edge and with rlast commit.
    send_frame(6, 5, 1'b0, good_expected(6, 5, 1'b0), 1'b1);
    send_frame(5, TO, 1'b0, good_expected(5, TO, 1'b0), 1'b1);
    send_frame(6, 0, 1'b0, good_expected(6, 0, 1'b0), 1'b1);
    wait_drain(200);
    check_cnts("t4");

    // Next frame starting before the verdict supersedes the pending one.
    send_frame(8, -1, 1'b0, 1'b0, 1'b0);
    send_frame(8, 3, 1'b0, good_expected(8, 3, 1'b0), 1'b1);
    wait_drain(200);
    check_cnts("t5");

    // Length boundary: 190 beats accepted, 191 dropped without raising overflow.
    send_frame(MAXB, 1, 1'b0, good_expected(MAXB, 1, 1'b0), 1'b1);
    send_frame(MAXB + 1, 1, 1'b0, good_expected(MAXB + 1, 1, 1'b0), 1'b1);
    wait_drain(1000);
    check_cnts("len");
    check("ovf_after_oversize", 160'(ovf), 160'(0));

    // Stalled consumer: 5 x 100 beats fit, the 6th frame overflows.
    rdy_mode = 0;
    idle(2);
    for (int f = 0; f < 6; f++) send_frame(100, 0, 1'b0, (f < 5), 1'b1);
    idle(4);
    check("t3_overflow", 160'(ovf), 160'(1));
    check("t3_tvalid_stalled", 160'(tvalid), 160'(1));
    check_cnts("t3");
    rdy_mode = 1;
    wait_drain(2000);
    check_cnts("t3_drained");

    // Random traffic with random backpressure.
    ok0 = int'(ok_cnt);
    drop0 = int'(drop_cnt);
    rdy_mode = 2;
    for (int f = 0; f < 1000; f++) begin
      len = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, MAXB)) : int'($urandom_range(1, 16));
      err = ($urandom_range(0, 9) == 0);
      vd = int'($urandom_range(0, TO));
      wait_room(len);
      send_frame(len, vd, err, good_expected(len, vd, err), 1'b1);
    end
    wait_drain(20000);
    check_cnts("t6");
    check("t6_total_frames", 160'((int'(ok_cnt) - ok0) + (int'(drop_cnt) - drop0)), 160'(1000));
    check("t6_ovf_sticky", 160'(ovf), 160'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
